// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter with optional hold-limit revoke
//
// Shares one resource among four level-sensitive requesters. A grant is held
// until its owner drops its request or en falls. After any grant ends, the
// arbiter spends at least one cycle idle before granting again.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   - a grant is force-revoked after MAX_HOLD cycles, and timeout pulses
//   undefined - no hold counter; timeout is tied to 0
//
// Parameters
//   MAX_HOLD  grant cycle limit when ARB_TIMEOUT_EN is defined (1 .. 2**CNT_W-1)
//   CNT_W     hold counter width
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   arbiter enable; 0 revokes the grant and blocks new grants
//   req[3:0]   in   level requests
//   gnt[3:0]   out  registered one-hot grant, 0000 when there is no owner
//   gnt_id     out  registered owner index, qualified by gnt_valid
//   gnt_valid  out  registered, 1 while gnt is non-zero
//   timeout    out  one-cycle pulse on a forced revoke
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD out of range for CNT_W");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, next_state;
    logic [1:0] ptr, next_ptr;
    logic [3:0] next_gnt;
    logic [1:0] next_gnt_id;
    logic       next_gnt_valid;

    logic [1:0] win;
    logic       found;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt, next_hold_cnt;
    logic             timeout_q, next_timeout;
`endif

    // Rotating-priority search: candidates ptr+1, ptr+2, ptr+3, ptr (mod 4).
    always_comb begin
        logic [1:0] idx;
        idx   = '0;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        next_state     = state;
        next_ptr       = ptr;
        next_gnt       = gnt;
        next_gnt_id    = gnt_id;
        next_gnt_valid = gnt_valid;
`ifdef ARB_TIMEOUT_EN
        next_hold_cnt  = hold_cnt;
        next_timeout   = 1'b0;
`endif
        case (state)
            IDLE: begin
                next_gnt       = 4'b0000;
                next_gnt_valid = 1'b0;
                if (en && found) begin
                    next_state     = GRANT;
                    next_gnt       = 4'b0001 << win;
                    next_gnt_id    = win;
                    next_gnt_valid = 1'b1;
                    next_ptr       = win;
`ifdef ARB_TIMEOUT_EN
                    next_hold_cnt  = '0;
`endif
                end
            end
            GRANT: begin
                // Release beats any other request; arbitration waits for IDLE.
                if (!en || !req[gnt_id]) begin
                    next_state     = IDLE;
                    next_gnt       = 4'b0000;
                    next_gnt_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    // ptr already equals the owner, so it re-enters lowest in rotation.
                    next_state     = IDLE;
                    next_gnt       = 4'b0000;
                    next_gnt_valid = 1'b0;
                    next_timeout   = 1'b1;
                end else begin
                    next_hold_cnt  = hold_cnt + 1'b1;
`endif
                end
            end
            default: begin
                next_state     = IDLE;
                next_gnt       = 4'b0000;
                next_gnt_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= next_state;
            ptr       <= next_ptr;
            gnt       <= next_gnt;
            gnt_id    <= next_gnt_id;
            gnt_valid <= next_gnt_valid;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= next_hold_cnt;
            timeout_q <= next_timeout;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
